// File: rtl/fifo_sync_buf_pkg.sv
// Shared types, mode constants and pointer-compare helpers for the synchronous FIFO.
package fifo_sync_buf_pkg;

    // Widest pointer the helpers can compare (ADDRSIZE+1 must fit in this).
    localparam int PTR_MAX_W = 32;

    // Pointer container: a FIFO's (ADDRSIZE+1)-bit pointer is zero-extended into it.
    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Read-port modes.
    localparam int SHOWAHEAD_OFF = 0;
    localparam int SHOWAHEAD_ON  = 1;

    typedef enum logic {
        SHOW_STANDARD = 1'b0,
        SHOW_AHEAD    = 1'b1
    } show_mode_e;

    // Mask covering the wrap bit plus the address bits.
    function automatic ptr_word_t ptr_mask(input int addr_bits);
        return (ptr_word_t'(1) << (addr_bits + 1)) - ptr_word_t'(1);
    endfunction

    // Full: wrap bits differ while the address bits match.
    function automatic logic ptrs_full(input ptr_word_t wptr, input ptr_word_t rptr,
                                       input int addr_bits);
        ptr_word_t diff;
        diff = (wptr ^ rptr) & ptr_mask(addr_bits);
        return diff == (ptr_word_t'(1) << addr_bits);
    endfunction

    // Empty: both pointers identical including the wrap bit.
    function automatic logic ptrs_empty(input ptr_word_t wptr, input ptr_word_t rptr,
                                        input int addr_bits);
        ptr_word_t diff;
        diff = (wptr ^ rptr) & ptr_mask(addr_bits);
        return diff == '0;
    endfunction

endpackage

// File: rtl/fifo_sync_buf_ram.sv
// Simple dual-port storage array: synchronous write, registered synchronous read, no reset.
module fifo_sync_buf_ram #(
    parameter int DATASIZE = 128,
    parameter int ADDRSIZE = 9
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];

    // Store the incoming word when a write is granted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its last value while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync_buf.sv
// Single-clock FIFO with registered or show-ahead read port, fill count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module fifo_sync_buf
    import fifo_sync_buf_pkg::*;
#(
    parameter int DATASIZE  = 128,
    parameter int ADDRSIZE  = 9,
    parameter int SHOWAHEAD = SHOWAHEAD_OFF,
    parameter int AFULL_TH  = (1 << ADDRSIZE) - 4,
    parameter int AEMPTY_TH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                clr_err,
    input  logic                wr_en,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rd_en,
    output logic [DATASIZE-1:0] rdata,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int         DEPTH     = 1 << ADDRSIZE;
    localparam show_mode_e MODE      = (SHOWAHEAD == SHOWAHEAD_ON) ? SHOW_AHEAD : SHOW_STANDARD;
    localparam bit         AEMPTY_EN = (AEMPTY_TH >= 0);

    typedef logic [ADDRSIZE:0] ptr_t;

    localparam ptr_t PTR_ONE  = ptr_t'(1);
    localparam ptr_t DEPTH_V  = ptr_t'(DEPTH);
    localparam ptr_t AFULL_V  = ptr_t'(AFULL_TH);
    localparam ptr_t AEMPTY_V = ptr_t'((AEMPTY_TH < 0) ? 0 : AEMPTY_TH);

    if (ADDRSIZE + 1 > PTR_MAX_W) begin : g_bad_addrsize
        $error("fifo_sync_buf: ADDRSIZE too large for pointer helpers");
    end
    if (AFULL_TH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_buf: AFULL_TH must not exceed DEPTH");
    end
    if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
        $error("fifo_sync_buf: AEMPTY_TH must be below DEPTH");
    end

    ptr_t                wptr;
    ptr_t                rptr;
    ptr_t                count_q;
    logic                head_valid;
    logic                rd_loaded;
    logic                ovf_q;
    logic                unf_q;
    logic                ram_empty;
    logic                full_int;
    logic                empty_int;
    logic                wr_acc;
    logic                rd_acc;
    logic                fetch;
    logic [DATASIZE-1:0] ram_rdata;

    // Flags from registered state, request acceptance and RAM read (fetch) control.
    always_comb begin
        ram_empty = ptrs_empty(ptr_word_t'(wptr), ptr_word_t'(rptr), ADDRSIZE);
        full_int  = 1'b0;
        empty_int = 1'b1;
        fetch     = 1'b0;
        if (MODE == SHOW_AHEAD) begin
            full_int  = (count_q == DEPTH_V);
            empty_int = !head_valid;
        end else begin
            full_int  = ptrs_full(ptr_word_t'(wptr), ptr_word_t'(rptr), ADDRSIZE);
            empty_int = (count_q == '0);
        end
        wr_acc = wr_en && !full_int && !flush;
        rd_acc = rd_en && !empty_int && !flush;
        if (MODE == SHOW_AHEAD) begin
            fetch = !flush && !ram_empty && (!head_valid || rd_acc);
        end else begin
            fetch = rd_acc;
        end
    end

    fifo_sync_buf_ram #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[ADDRSIZE-1:0]),
        .wdata (wdata),
        .re    (fetch),
        .raddr (rptr[ADDRSIZE-1:0]),
        .rdata (ram_rdata)
    );

    // Pointers, fill count and head-word tracking; flush returns them to the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            head_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (fetch) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: ;
            endcase
            if (fetch) begin
                head_valid <= 1'b1;
            end else if (rd_acc) begin
                head_valid <= 1'b0;
            end
        end
    end

    // Marks that the RAM output register holds real data, so rdata reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_loaded <= 1'b0;
        end else if (fetch) begin
            rd_loaded <= 1'b1;
        end
    end

    // Sticky error flags: a new offence outranks clr_err, flush clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && full_int) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rd_en && empty_int) begin
                unf_q <= 1'b1;
            end else if (clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign rdata        = rd_loaded ? ram_rdata : '0;
    assign full         = full_int;
    assign empty        = empty_int;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_V);
    assign almost_empty = AEMPTY_EN && (count_q <= AEMPTY_V);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
